// File: rtl/lk_pkg.sv
// Shared definitions for the Lucas-Kanade optical-flow pipeline.
//   lk_pix_t      : 32-bit pixel word carried between pipeline blocks
//   LK_SIDE_DEF   : default gradient window side
//   lk_win_words  : number of words in a fetched window, (side+2)^2; the
//                   window fetch and gradient blocks size their flat window
//                   arrays from this.
package lk_pkg;

  typedef logic [31:0] lk_pix_t;

  localparam int LK_SIDE_DEF = 3;

  function automatic int lk_win_words(input int side);
    return (side + 2) * (side + 2);
  endfunction

endpackage

// File: rtl/lk_window_fetch_if.sv
// Handshake and window bus of lk_window_fetch.
//   in_val/in_rdy, in_cur, in_nxt        : pixel-pair input stream
//   out_val/out_rdy, out_cur_win/_nxt_win : window output stream, element
//                                           i*W+j, row 0 oldest, col 0 left
//   out_x/out_y                           : window top-left coordinate, only
//                                           when LK_WIN_COORD_EN is defined
// Modports: slave = the window fetch block, master = the upstream/downstream
// side that drives pixels and accepts windows.
interface lk_window_fetch_if
  import lk_pkg::*;
#(
  parameter int SIDE = LK_SIDE_DEF
`ifdef LK_WIN_COORD_EN
  ,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
`endif
);

  localparam int WW = lk_win_words(SIDE);

  logic              in_val;
  logic              in_rdy;
  lk_pix_t           in_cur;
  lk_pix_t           in_nxt;
  logic              out_val;
  logic              out_rdy;
  lk_pix_t [WW-1:0]  out_cur_win;
  lk_pix_t [WW-1:0]  out_nxt_win;

`ifdef LK_WIN_COORD_EN
  logic [$clog2(IMG_W)-1:0] out_x;
  logic [$clog2(IMG_H)-1:0] out_y;

  modport slave (
    input  in_val, in_cur, in_nxt, out_rdy,
    output in_rdy, out_val, out_cur_win, out_nxt_win, out_x, out_y
  );

  modport master (
    output in_val, in_cur, in_nxt, out_rdy,
    input  in_rdy, out_val, out_cur_win, out_nxt_win, out_x, out_y
  );
`else
  modport slave (
    input  in_val, in_cur, in_nxt, out_rdy,
    output in_rdy, out_val, out_cur_win, out_nxt_win
  );

  modport master (
    output in_val, in_cur, in_nxt, out_rdy,
    input  in_rdy, out_val, out_cur_win, out_nxt_win
  );
`endif

endinterface

// File: rtl/lk_line_window.sv
// Line buffers plus sliding window register for one frame stream.
//   clk, reset : clock, asynchronous active-high reset (window register only)
//   shift_i    : an input transfer happens this cycle
//   col_i      : column of the incoming pixel
//   pix_i      : incoming pixel
//   win_o      : W x W window, element i*W+j, row 0 oldest line
// The W-1 line buffers hold the previous W-1 image lines; line 0 is the
// oldest. They are intentionally not reset: the controller only flags a
// window once every row in it belongs to the current frame.
module lk_line_window
  import lk_pkg::*;
#(
  parameter int SIDE  = LK_SIDE_DEF,
  parameter int IMG_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift_i,
  input  logic [$clog2(IMG_W)-1:0]   col_i,
  input  lk_pix_t                    pix_i,
  output lk_pix_t [lk_win_words(SIDE)-1:0] win_o
);

  localparam int W  = SIDE + 2;
  localparam int WW = lk_win_words(SIDE);

  lk_pix_t          col_rd [W-1];
  lk_pix_t [WW-1:0] win_p1;
  lk_pix_t [WW-1:0] win_d;

  // Line storage: column col_i moves up one line, new pixel enters bottom
  for (genvar l = 0; l < W - 1; l++) begin : g_line
    lk_pix_t line_q [IMG_W];

    assign col_rd[l] = line_q[col_i];

    if (l == W - 2) begin : g_bottom
      always_ff @(posedge clk) begin
        if (shift_i) line_q[col_i] <= pix_i;
      end
    end else begin : g_upper
      always_ff @(posedge clk) begin
        if (shift_i) line_q[col_i] <= col_rd[l + 1];
      end
    end
  end

  // Window: shift left one column, new right column = buffered column + pixel
  always_comb begin
    win_d = win_p1;
    if (shift_i) begin
      for (int i = 0; i < W; i++) begin
        for (int j = 0; j < W - 1; j++) begin
          win_d[i*W + j] = win_p1[i*W + j + 1];
        end
      end
      for (int i = 0; i < W - 1; i++) begin
        win_d[i*W + W - 1] = col_rd[i];
      end
      win_d[(W-1)*W + W - 1] = pix_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_p1 <= '0;
    else       win_p1 <= win_d;
  end

  assign win_o = win_p1;

endmodule

// File: rtl/lk_window_fetch.sv
// Streaming (side+2)x(side+2) window generator for the current and next
// frame, feeding the Lucas-Kanade gradient stage.
//   clk   : single clock
//   reset : asynchronous, active-high
//   bus   : lk_window_fetch_if.slave -- pixel-pair input stream, window
//           output stream (and out_x/out_y when LK_WIN_COORD_EN is defined)
// Build option LK_WIN_COORD_EN: adds registered window top-left coordinates.
// One raster counter pair and the handshake are shared by two
// lk_line_window instances (current and next frame).
module lk_window_fetch
  import lk_pkg::*;
#(
  parameter int SIDE  = LK_SIDE_DEF,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input logic              clk,
  input logic              reset,
  lk_window_fetch_if.slave bus
);

  localparam int W  = SIDE + 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_EMIT = CW'(W - 1);
  localparam logic [RW-1:0] ROW_EMIT = RW'(W - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          vld_p1, vld_d;
  logic          in_rdy;
  logic          xfer_in;
  logic          emit;

  // Input is accepted whenever the output slot is empty or being drained
  assign in_rdy  = !vld_p1 || bus.out_rdy;
  assign xfer_in = bus.in_val && in_rdy;
  assign emit    = xfer_in && (row_q >= ROW_EMIT) && (col_q >= COL_EMIT);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (xfer_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // An emitting transfer always refills the slot; otherwise a dequeue empties it
  always_comb begin
    vld_d = vld_p1;
    if (emit)                       vld_d = 1'b1;
    else if (vld_p1 && bus.out_rdy) vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vld_p1 <= vld_d;
    end
  end

  // Stage p1: window registers for both frames
  lk_line_window #(
    .SIDE  (SIDE),
    .IMG_W (IMG_W)
  ) u_cur (
    .clk     (clk),
    .reset   (reset),
    .shift_i (xfer_in),
    .col_i   (col_q),
    .pix_i   (bus.in_cur),
    .win_o   (bus.out_cur_win)
  );

  lk_line_window #(
    .SIDE  (SIDE),
    .IMG_W (IMG_W)
  ) u_nxt (
    .clk     (clk),
    .reset   (reset),
    .shift_i (xfer_in),
    .col_i   (col_q),
    .pix_i   (bus.in_nxt),
    .win_o   (bus.out_nxt_win)
  );

`ifdef LK_WIN_COORD_EN
  logic [CW-1:0] x_q, x_d;
  logic [RW-1:0] y_q, y_d;

  // Coordinates change only on an emitting transfer, so they track the window
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (emit) begin
      x_d = col_q - COL_EMIT;
      y_d = row_q - ROW_EMIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign bus.out_x = x_q;
  assign bus.out_y = y_q;
`endif

  assign bus.in_rdy  = in_rdy;
  assign bus.out_val = vld_p1;

endmodule

// File: tb/tb_lk_window_fetch.sv
module tb_lk_window_fetch;
  import lk_pkg::*;

  localparam int SIDE  = 3;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int W     = SIDE + 2;
  localparam int WW    = W * W;
  localparam int NWIN  = (IMG_H - W + 1) * (IMG_W - W + 1);
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lk_window_fetch_if #(
    .SIDE (SIDE)
`ifdef LK_WIN_COORD_EN
    , .IMG_W (IMG_W), .IMG_H (IMG_H)
`endif
  ) bus ();

  lk_window_fetch #(
    .SIDE  (SIDE),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // out_rdy: fixed level or random per cycle
  logic rdy_val  = 1'b1;
  logic rnd_mode = 1'b0;
  logic rnd_bit  = 1'b1;
  assign bus.out_rdy = rnd_mode ? rnd_bit : rdy_val;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void chk_win(input string nm, input logic [WW*32-1:0] act,
                                  input logic [WW*32-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int e = 0; e < WW; e++) begin
        if (act[e*32 +: 32] !== exp[e*32 +: 32]) begin
          $display("FAIL %s: element %0d got %0d, expected %0d", nm, e,
                   act[e*32 +: 32], exp[e*32 +: 32]);
          break;
        end
      end
    end
  endfunction

  // Reference window: pixel value = y*IMG_W + x + off
  function automatic logic [WW*32-1:0] model(input int x0, input int y0, input int off);
    logic [WW*32-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        r[(i*W + j)*32 +: 32] = 32'((y0 + i) * IMG_W + x0 + j + off);
    return r;
  endfunction

  // Windows seen leaving the block
  typedef struct {
    logic [WW*32-1:0] c;
    logic [WW*32-1:0] n;
    int               x;
    int               y;
  } rec_t;
  rec_t q[$];

  always @(negedge clk) begin
    if (bus.out_val === 1'b1 && bus.out_rdy === 1'b1) begin
      rec_t r;
      r.c = bus.out_cur_win;
      r.n = bus.out_nxt_win;
`ifdef LK_WIN_COORD_EN
      r.x = int'(bus.out_x);
      r.y = int'(bus.out_y);
`else
      r.x = 0;
      r.y = 0;
`endif
      q.push_back(r);
    end
  end

  // First-frame expected windows, hand-computed
  typedef struct {
    int          x0;
    int          y0;
    logic [31:0] c0;
    logic [31:0] c12;
    logic [31:0] c24;
    logic [31:0] n24;
  } vec_t;
  vec_t tbl [NWIN];

  task automatic send(input logic [31:0] c, input logic [31:0] n, input int gap);
    int tmo;
    bus.in_val = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    bus.in_val = 1'b1;
    bus.in_cur = c;
    bus.in_nxt = n;
    tmo = 0;
    @(negedge clk);
    while (bus.in_rdy !== 1'b1 && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (bus.in_rdy !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: pixel %0d not accepted, in_rdy=%0b, expected 1", c, bus.in_rdy);
    end
    @(posedge clk);
    #1;
    bus.in_val = 1'b0;
  endtask

  task automatic stream_range(input int p0, input int p1, input int off,
                              input bit gaps, input bit chkv);
    for (int p = p0; p <= p1; p++) begin
      send(32'(p), 32'(p + off), gaps ? int'($urandom_range(0, 2)) : 0);
      if (chkv)
        chk($sformatf("s1_out_val_p%0d", p), 64'(bus.out_val),
            64'((p % IMG_W) >= W - 1 && (p / IMG_W) >= W - 1));
    end
  endtask

  task automatic drain();
    rnd_mode = 1'b0;
    rdy_val  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_queue(input string nm, input int nframes, input int off0, input int off1);
    int n;
    chk({nm, "_nwin"}, 64'(q.size()), 64'(nframes * NWIN));
    n = (q.size() < nframes * NWIN) ? q.size() : nframes * NWIN;
    for (int k = 0; k < n; k++) begin
      int f, w, x0, y0;
      f  = k / NWIN;
      w  = k % NWIN;
      x0 = w % (IMG_W - W + 1);
      y0 = w / (IMG_W - W + 1);
      chk_win($sformatf("%s_cur_w%0d", nm, k), q[k].c, model(x0, y0, 0));
      chk_win($sformatf("%s_nxt_w%0d", nm, k), q[k].n, model(x0, y0, (f == 0) ? off0 : off1));
`ifdef LK_WIN_COORD_EN
      chk($sformatf("%s_x_w%0d", nm, k), 64'(q[k].x), 64'(x0));
      chk($sformatf("%s_y_w%0d", nm, k), 64'(q[k].y), 64'(y0));
`endif
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, finished=0, expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW*32-1:0] snap_c, snap_n;

    tbl[0] = '{0, 0,  0, 18, 36, 1036};
    tbl[1] = '{1, 0,  1, 19, 37, 1037};
    tbl[2] = '{2, 0,  2, 20, 38, 1038};
    tbl[3] = '{3, 0,  3, 21, 39, 1039};
    tbl[4] = '{0, 1,  8, 26, 44, 1044};
    tbl[5] = '{1, 1,  9, 27, 45, 1045};
    tbl[6] = '{2, 1, 10, 28, 46, 1046};
    tbl[7] = '{3, 1, 11, 29, 47, 1047};

    reset      = 1'b1;
    bus.in_val = 1'b0;
    bus.in_cur = '0;
    bus.in_nxt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out_val", 64'(bus.out_val), 64'd0);
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    chk_win("rst_cur_win", bus.out_cur_win, '0);
    chk_win("rst_nxt_win", bus.out_nxt_win, '0);
`ifdef LK_WIN_COORD_EN
    chk("rst_out_x", 64'(bus.out_x), 64'd0);
    chk("rst_out_y", 64'(bus.out_y), 64'd0);
`endif

    // One frame, gap-free, out_rdy high; out_val checked after every pixel
    q.delete();
    stream_range(0, NPIX - 1, 1000, 1'b0, 1'b1);
    drain();
    chk("s1_nwin", 64'(q.size()), 64'(NWIN));
    for (int k = 0; k < NWIN && k < q.size(); k++) begin
      chk($sformatf("s1_cur0_w%0d", k),  64'(q[k].c[0*32 +: 32]),  64'(tbl[k].c0));
      chk($sformatf("s1_cur12_w%0d", k), 64'(q[k].c[12*32 +: 32]), 64'(tbl[k].c12));
      chk($sformatf("s1_cur24_w%0d", k), 64'(q[k].c[24*32 +: 32]), 64'(tbl[k].c24));
      chk($sformatf("s1_nxt24_w%0d", k), 64'(q[k].n[24*32 +: 32]), 64'(tbl[k].n24));
      chk_win($sformatf("s1_cur_w%0d", k), q[k].c, model(tbl[k].x0, tbl[k].y0, 0));
      chk_win($sformatf("s1_nxt_w%0d", k), q[k].n, model(tbl[k].x0, tbl[k].y0, 1000));
`ifdef LK_WIN_COORD_EN
      chk($sformatf("s1_x_w%0d", k), 64'(q[k].x), 64'(tbl[k].x0));
      chk($sformatf("s1_y_w%0d", k), 64'(q[k].y), 64'(tbl[k].y0));
`endif
    end

    // Backpressure: hold the first window for 5 cycles with a pixel waiting
    q.delete();
    stream_range(0, 36, 1000, 1'b0, 1'b0);
    rdy_val = 1'b0;
    snap_c  = bus.out_cur_win;
    snap_n  = bus.out_nxt_win;
    chk_win("s2_first_cur", snap_c, model(0, 0, 0));
    bus.in_val = 1'b1;
    bus.in_cur = 32'd37;
    bus.in_nxt = 32'd1037;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("s2_in_rdy_c%0d", s), 64'(bus.in_rdy), 64'd0);
      chk($sformatf("s2_out_val_c%0d", s), 64'(bus.out_val), 64'd1);
      chk_win($sformatf("s2_hold_cur_c%0d", s), bus.out_cur_win, snap_c);
      chk_win($sformatf("s2_hold_nxt_c%0d", s), bus.out_nxt_win, snap_n);
      @(posedge clk);
      #1;
    end
    rdy_val    = 1'b1;
    bus.in_val = 1'b0;
    stream_range(37, NPIX - 1, 1000, 1'b0, 1'b0);
    drain();
    check_queue("s2", 1, 1000, 1000);

    // Two back-to-back frames, next-frame offset changes in frame 2
    q.delete();
    stream_range(0, NPIX - 1, 1000, 1'b0, 1'b0);
    stream_range(0, NPIX - 1, 2000, 1'b0, 1'b0);
    drain();
    check_queue("s3", 2, 1000, 2000);
    if (q.size() > NWIN)
      chk("s3_f2_nxt0", 64'(q[NWIN].n[31:0]), 64'd2000);
    else
      chk("s3_f2_present", 64'(q.size()), 64'(NWIN + 1));

    // Mid-frame reset while a window is held, then restart the frame
    stream_range(0, 36, 1000, 1'b0, 1'b0);
    rdy_val = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("s4_out_val_async", 64'(bus.out_val), 64'd0);
    chk("s4_in_rdy_async", 64'(bus.in_rdy), 64'd1);
    chk_win("s4_cur_win_rst", bus.out_cur_win, '0);
    @(posedge clk);
    #2;
    reset   = 1'b0;
    rdy_val = 1'b1;
    #1;
    q.delete();
    @(posedge clk);
    #1;
    stream_range(0, NPIX - 1, 1000, 1'b0, 1'b0);
    drain();
    check_queue("s4", 1, 1000, 1000);

    // Random input gaps and output backpressure over two frames
    q.delete();
    rnd_mode = 1'b1;
    stream_range(0, NPIX - 1, 1000, 1'b1, 1'b0);
    stream_range(0, NPIX - 1, 2000, 1'b1, 1'b0);
    drain();
    check_queue("s5", 2, 1000, 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
